rr_mux_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 4:1 mux datapath among 4 requesters.
//  - Grants one requester at a time.
//  - Drives the mux select pair (s1,s0) from the granted index.
//  - Registers the selected data onto a single output.
//  - Sits between the requesting sources and the gate-level 4x1 mux.

---
 rtl/rr_mux_arbiter_pkg.sv | 17 +
 rtl/rr_mux_arbiter_if.sv | 26 ++
 rtl/rr_mux_arbiter_pick4.sv | 27 ++
 rtl/rr_mux_arbiter.sv | 126 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants, FSM state encoding and helpers for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

    localparam int N_SRC = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [N_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester/mux-side bundle of the round-robin arbiter: requests and data in, grant/select/data out.
interface rr_mux_arbiter_if #(
    parameter int W = 1
);
    import rr_mux_arbiter_pkg::*;

    logic [N_SRC-1:0]   req;
    logic [N_SRC*W-1:0] d;
    logic [N_SRC-1:0]   gnt;
    logic               s1;
    logic               s0;
    logic               busy;
    logic [W-1:0]       data_out;
    logic               data_valid;

    modport master (
        output req, d,
        input  gnt, s1, s0, busy, data_out, data_valid
    );

    modport slave (
        input  req, d,
        output gnt, s1, s0, busy, data_out, data_valid
    );

endinterface

// File: rtl/rr_mux_arbiter_pick4.sv
// rr_pick4: combinational rotate-priority encoder; scans from (last+1) upward with wrap.
module rr_pick4
    import rr_mux_arbiter_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Walk from lowest to highest priority so the closest hit after 'last' wins.
    always_comb begin
        any  = 1'b0;
        idx  = last;
        cand = last;
        for (int k = N_SRC; k >= 1; k--) begin
            cand = last + SEL_W'(k);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux select and registering the selected data.
// Optional owner timeout enabled by defining ARB_TIMEOUT_EN (limit set by HOLD_MAX).
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int W        = 1,
    parameter int HOLD_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    rr_mux_arbiter_if.slave bus
);

    state_e           state_q;
    logic [SEL_W-1:0] last_q;
    logic [SEL_W-1:0] sel_q;
    logic [N_SRC-1:0] gnt_q;
    logic             busy_q;
    logic [W-1:0]     dout_q;
    logic             dvalid_q;

    logic [N_SRC-1:0] others;
    logic [N_SRC-1:0] pick_req;
    logic [SEL_W-1:0] pick_last;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             rotate;
    logic [W-1:0]     mux_out;

    // While granted, the owner is excluded so the pick always yields the next source in rotation.
    assign others    = bus.req & ~onehot(sel_q);
    assign pick_req  = (state_q == ST_GRANT) ? others : bus.req;
    assign pick_last = (state_q == ST_GRANT) ? sel_q  : last_q;

    rr_pick4 u_pick (
        .req  (pick_req),
        .last (pick_last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] hold_q;
    logic             timeout;

    assign timeout = (hold_q == HOLD_LAST) && (|others);
    assign rotate  = !bus.req[sel_q] || timeout;
`else
    assign rotate  = !bus.req[sel_q];
`endif

    // Bit-sliced 4:1 mux; sel_q is the register behind s1/s0.
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        logic [N_SRC-1:0] col;
        for (genvar si = 0; si < N_SRC; si++) begin : g_src
            assign col[si] = bus.d[si*W + gi];
        end
        assign mux_out[gi] = col[sel_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= SEL_W'(N_SRC - 1);
            sel_q    <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dvalid_q <= 1'b0;
                    if (pick_any) begin
                        gnt_q   <= onehot(pick_idx);
                        sel_q   <= pick_idx;
                        busy_q  <= 1'b1;
                        state_q <= ST_GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    dout_q   <= mux_out;
                    dvalid_q <= 1'b1;
                    if (rotate) begin
                        last_q <= sel_q;
`ifdef ARB_TIMEOUT_EN
                        hold_q <= '0;
`endif
                        if (pick_any) begin
                            gnt_q <= onehot(pick_idx);
                            sel_q <= pick_idx;
                        end else begin
                            gnt_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        if (hold_q != HOLD_LAST) begin
                            hold_q <= hold_q + 1'b1;
                        end
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.s1         = sel_q[1];
    assign bus.s0         = sel_q[0];
    assign bus.busy       = busy_q;
    assign bus.data_out   = dout_q;
    assign bus.data_valid = dvalid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed + randomized bench for rr_mux_arbiter against a cycle-level behavioural model.
module tb_rr_mux_arbiter;
    import rr_mux_arbiter_pkg::*;

    localparam int W        = 2;
    localparam int HOLD_MAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.W(W)) bus ();

    rr_mux_arbiter #(.W(W), .HOLD_MAX(HOLD_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: owner index (-1 = nobody), rotation pointer, hold length, output registers.
    int           m_owner = -1;
    int           m_last  = 3;
    int           m_hold  = 0;
    int           m_sel   = 0;
    logic [W-1:0] m_dout  = '0;
    logic         m_valid = 1'b0;

    function automatic int first_from(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r_rst, input logic [3:0] r, input logic [4*W-1:0] dd);
        logic [3:0] oth;
        bit         leave;
        int         p;
        if (r_rst) begin
            m_owner = -1; m_last = 3; m_hold = 0; m_sel = 0; m_dout = '0; m_valid = 1'b0;
        end else if (m_owner < 0) begin
            m_valid = 1'b0;
            p = first_from(r, (m_last + 1) % 4);
            if (p >= 0) begin
                m_owner = p; m_sel = p; m_hold = 0;
            end
        end else begin
            m_dout  = dd[m_owner*W +: W];
            m_valid = 1'b1;
            oth     = r;
            oth[m_owner] = 1'b0;
            leave   = !r[m_owner];
`ifdef ARB_TIMEOUT_EN
            if (m_hold == HOLD_MAX - 1 && oth != 4'b0) leave = 1'b1;
`endif
            if (leave) begin
                m_last = m_owner;
                m_hold = 0;
                p = first_from(oth, (m_owner + 1) % 4);
                m_owner = p;
                if (p >= 0) m_sel = p;
            end else if (m_hold < HOLD_MAX - 1) begin
                m_hold++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
        check("gnt",        32'(bus.gnt), 32'(eg));
        check("sel",        32'({bus.s1, bus.s0}), 32'(m_sel));
        check("busy",       32'(bus.busy), 32'(m_owner >= 0));
        check("data_out",   32'(bus.data_out), 32'(m_dout));
        check("data_valid", 32'(bus.data_valid), 32'(m_valid));
    endtask

    task automatic step();
        logic             r_rst;
        logic [3:0]       r;
        logic [4*W-1:0]   dd;
        r_rst = rst; r = bus.req; dd = bus.d;
        @(posedge clk);
        model_edge(r_rst, r, dd);
        #1;
        check_all();
        $display("t=%0t rst=%b req=%b gnt=%b sel=%0d busy=%b dout=%0h dv=%b",
                 $time, r_rst, r, bus.gnt, {bus.s1, bus.s0}, bus.busy, bus.data_out, bus.data_valid);
    endtask

    logic [3:0] gseq[$];
    logic [3:0] prev_g;
    logic [3:0] fair_exp [5];
    int         held;
    int         prev_o;

    initial begin
        // 1: reset with all requests high
        rst = 1'b1; bus.req = 4'b1111; bus.d = '0;
        step(); step();
        check("rst_gnt",  32'(bus.gnt), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_dv",   32'(bus.data_valid), 32'h0);

        // 2: single request from source 2
        rst = 1'b0; bus.req = 4'b0100; bus.d = '0; bus.d[2*W +: W] = W'(1);
        step();
        check("t2_gnt",  32'(bus.gnt), 32'h4);
        check("t2_sel",  32'({bus.s1, bus.s0}), 32'h2);
        check("t2_busy", 32'(bus.busy), 32'h1);
        step();
        check("t2_dout", 32'(bus.data_out), 32'h1);
        check("t2_dv",   32'(bus.data_valid), 32'h1);
        bus.req = 4'b0000;
        step();
        check("t2_drop_gnt",  32'(bus.gnt), 32'h0);
        check("t2_drop_busy", 32'(bus.busy), 32'h0);

        // 3: fairness, each owner drops its request after two granted cycles
        rst = 1'b1; step(); rst = 1'b0;
        bus.req = 4'b1111; held = 0; prev_o = -1; prev_g = 4'b0;
        for (int c = 0; c < 10; c++) begin
            bus.d = W'($urandom) | (4*W)'($urandom) << W;
            step();
            if (bus.gnt != prev_g) gseq.push_back(bus.gnt);
            prev_g = bus.gnt;
            if (m_owner == prev_o) held++;
            else begin held = 1; prev_o = m_owner; end
            bus.req = 4'b1111;
            if (held == 2 && m_owner >= 0) bus.req[m_owner] = 1'b0;
        end
        fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 5; k++) begin
            check($sformatf("fair_seq%0d", k), (k < gseq.size()) ? 32'(gseq[k]) : 32'hFFFF, 32'(fair_exp[k]));
        end

        // 4: two contenders held high
        rst = 1'b1; step(); rst = 1'b0;
        bus.req = 4'b0011;
        for (int c = 0; c < 16; c++) step();
`ifdef ARB_TIMEOUT_EN
        check("t4_gnt", 32'(bus.gnt), 32'h2);
`else
        check("t4_gnt", 32'(bus.gnt), 32'h1);
`endif

        // 5: lone owner beyond HOLD_MAX
        rst = 1'b1; step(); rst = 1'b0;
        bus.req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            step();
            check("t5_gnt", 32'(bus.gnt), 32'h1);
        end

        // 6: reset mid-grant
        rst = 1'b1; step(); rst = 1'b0;
        bus.req = 4'b0100;
        step(); step();
        check("t6_owner", 32'(bus.gnt), 32'h4);
        rst = 1'b1;
        step();
        check("t6_rst_gnt", 32'(bus.gnt), 32'h0);
        rst = 1'b0; bus.req = 4'b1111;
        step();
        check("t6_first", 32'(bus.gnt), 32'h1);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 300; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) != 0) bus.req = 4'($urandom);
            bus.d = (4*W)'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
